// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage with PC, IF/ID register, branch redirect, stall and saturating issue count
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_branch_eq,
    input  logic        i_branch_ne,
    input  logic        i_zero,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic [5:0]  o_op,
    output logic [15:0] o_instr_count
);
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [15:0] r_count;
    logic        w_redirect;
    logic [31:0] w_pc4;

    // Branch resolution from EX and sequential next PC
    always_comb begin
        w_redirect = (i_branch_eq & i_zero) | (i_branch_ne & ~i_zero);
        w_pc4      = r_pc + 32'd4;
    end

    // PC and IF/ID update: reset > redirect > stall > normal fetch
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc    <= PC_RESET;
            r_instr <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            r_count <= 16'd0;
        end else if (w_redirect) begin
            r_pc    <= {i_branch_target[31:2], 2'b00};
            r_instr <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_pc    <= w_pc4;
            r_instr <= i_imem_rdata;
            r_pc4   <= w_pc4;
            r_valid <= 1'b1;
            r_count <= (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_if_id_instr = r_instr;
    assign o_if_id_pc4   = r_pc4;
    assign o_if_id_valid = r_valid;
    assign o_op          = r_instr[31:26];
    assign o_instr_count = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against a behavioural model
module tb_fetch_stage;
    logic        clk = 0;
    logic        reset = 0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall = 0;
    logic        branch_eq = 0;
    logic        branch_ne = 0;
    logic        zero = 0;
    logic [31:0] branch_target = 0;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  op;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];

    longint unsigned m_pc = 0, m_pc4 = 0, m_instr = 0, m_cnt = 0;
    bit m_valid = 0;

    fetch_stage dut (
        .i_clk(clk), .i_reset(reset), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
        .i_stall(stall), .i_branch_eq(branch_eq), .i_branch_ne(branch_ne), .i_zero(zero),
        .i_branch_target(branch_target), .o_pc(pc), .o_if_id_instr(if_id_instr),
        .o_if_id_pc4(if_id_pc4), .o_if_id_valid(if_id_valid), .o_op(op), .o_instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at the reset vector, an address hash elsewhere
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h0040_0000) ? 32'h2008_0005 : ((a * 32'd2654435761) ^ 32'h1357_9BDF);
    endfunction

    assign imem_rdata = word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by that edge, queue the expected outcome
    task automatic step(input bit rst_n, input bit st, input bit beq, input bit bne, input bit z,
                        input logic [31:0] tgt);
        exp_t e;
        bit taken;
        reset = rst_n; stall = st; branch_eq = beq; branch_ne = bne; zero = z; branch_target = tgt;
        taken = z ? beq : bne;
        if (!rst_n) begin
            m_pc = 32'h0040_0000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        end else if (taken) begin
            m_pc = (tgt / 4) * 4; m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (!st) begin
            m_instr = word(m_pc[31:0]);
            m_pc = (m_pc + 4) % 64'h1_0000_0000;
            m_pc4 = m_pc;
            m_valid = 1;
            if (m_cnt < 65535) m_cnt++;
        end
        e.pc = m_pc[31:0]; e.instr = m_instr[31:0]; e.pc4 = m_pc4[31:0];
        e.valid = m_valid; e.cnt = m_cnt[15:0];
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: after each edge compare the DUT against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("imem_addr", imem_addr, e.pc);
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_pc4", if_id_pc4, e.pc4);
                chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
                chk("op", {26'd0, op}, {26'd0, e.instr[31:26]});
                chk("instr_count", {16'd0, instr_count}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 32'h1234_5678);
        repeat (4) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 32'h0040_0100);
        step(1, 0, 0, 1, 1, 32'h0000_0040);
        step(1, 0, 1, 1, 0, 32'h0040_0300);
        step(1, 0, 1, 1, 1, 32'h0040_0400);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 32'h0040_0203);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 32'hFFFF_FFFE);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 32'h0000_1000);
        repeat (300)
            step($urandom_range(39) != 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
                 $urandom_range(5) == 0, $urandom_range(1) == 1, $urandom);
        step(0, 0, 0, 0, 0, 0);
        repeat (65540) step(1, 0, 0, 0, 0, 0);
        repeat (2) step(1, 1, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 32'h0040_0000);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
